// File: rtl/fifo_rr_arbiter.sv
`default_nettype none
// fifo_rr_arbiter: round-robin drain of NUM_FIFOS input FIFOs into one downstream FIFO,
// with almost-full/full throttling and a sticky error freeze. Rev 1.0
module fifo_rr_arbiter #(
  parameter int NUM_FIFOS = 4,
  parameter int WORD_SIZE = 6,
  parameter int CNT_W     = 16
) (
  input  logic                           clk,
  input  logic                           reset_L,
  input  logic [NUM_FIFOS-1:0]           in_empty,
  input  logic [NUM_FIFOS-1:0]           in_error,
  input  logic [NUM_FIFOS*WORD_SIZE-1:0] in_data,
  input  logic                           out_almost_full,
  input  logic                           out_full,
  input  logic                           out_error,
  output logic [NUM_FIFOS-1:0]           in_rd,
  output logic                           out_wr,
  output logic [WORD_SIZE-1:0]           out_data,
  output logic [$clog2(NUM_FIFOS)-1:0]   grant,
  output logic [1:0]                     state,
  output logic [CNT_W-1:0]               xfer_count
);

  localparam int PTR_W = $clog2(NUM_FIFOS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    PAUSE  = 2'd2,
    ERROR  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 out_wr_q, out_wr_d;
  logic [WORD_SIZE-1:0] out_data_q, out_data_d;
  logic [PTR_W-1:0]     grant_q, grant_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [CNT_W-1:0]     xfer_count_q, xfer_count_d;

  logic                 err_any;
  logic                 stall;
  logic [NUM_FIFOS-1:0] req;
  logic                 issue;
  logic                 found;
  logic [PTR_W-1:0]     sel;
  logic [PTR_W-1:0]     idx;

  always_comb begin
    err_any = (|in_error) | out_error;
    stall   = out_almost_full | out_full;
    req     = ~in_empty;
    issue   = (state_q != ERROR) && !err_any && !stall && (req != '0);

    // Scan starting at the pointer; index arithmetic wraps because NUM_FIFOS is a power of 2.
    sel   = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NUM_FIFOS; k++) begin
      idx = ptr_q + PTR_W'(k);
      if (!found && req[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end

    in_rd = '0;
    if (issue && reset_L) begin
      in_rd[sel] = 1'b1;
    end

    out_wr_d     = issue;
    out_data_d   = out_data_q;
    grant_d      = grant_q;
    ptr_d        = ptr_q;
    xfer_count_d = xfer_count_q;
    if (issue) begin
      out_data_d   = in_data[sel*WORD_SIZE +: WORD_SIZE];
      grant_d      = sel;
      ptr_d        = sel + PTR_W'(1);
      xfer_count_d = xfer_count_q + CNT_W'(1);
    end

    if (err_any || state_q == ERROR) begin
      state_d = ERROR;
    end else if (stall && (req != '0)) begin
      state_d = PAUSE;
    end else if (issue) begin
      state_d = ACTIVE;
    end else begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      state_q      <= IDLE;
      out_wr_q     <= 1'b0;
      out_data_q   <= '0;
      grant_q      <= '0;
      ptr_q        <= '0;
      xfer_count_q <= '0;
    end else begin
      state_q      <= state_d;
      out_wr_q     <= out_wr_d;
      out_data_q   <= out_data_d;
      grant_q      <= grant_d;
      ptr_q        <= ptr_d;
      xfer_count_q <= xfer_count_d;
    end
  end

  assign out_wr     = out_wr_q;
  assign out_data   = out_data_q;
  assign grant      = grant_q;
  assign state      = state_q;
  assign xfer_count = xfer_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_rr_arbiter.sv
`default_nettype none
// tb_fifo_rr_arbiter: directed self-checking bench for fifo_rr_arbiter (4 FIFOs, 6-bit words).
`timescale 1ns/1ps
module tb_fifo_rr_arbiter;

  logic        clk;
  logic        reset_L;
  logic [3:0]  in_empty;
  logic [3:0]  in_error;
  logic [23:0] in_data;
  logic        out_almost_full;
  logic        out_full;
  logic        out_error;
  logic [3:0]  in_rd;
  logic        out_wr;
  logic [5:0]  out_data;
  logic [1:0]  grant;
  logic [1:0]  state;
  logic [15:0] xfer_count;

  int n_cmp = 0;
  int n_bad = 0;

  fifo_rr_arbiter #(.NUM_FIFOS(4), .WORD_SIZE(6), .CNT_W(16)) dut (
    .clk             (clk),
    .reset_L         (reset_L),
    .in_empty        (in_empty),
    .in_error        (in_error),
    .in_data         (in_data),
    .out_almost_full (out_almost_full),
    .out_full        (out_full),
    .out_error       (out_error),
    .in_rd           (in_rd),
    .out_wr          (out_wr),
    .out_data        (out_data),
    .grant           (grant),
    .state           (state),
    .xfer_count      (xfer_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_L         = 1'b0;
    in_empty        = 4'b0000;
    in_error        = 4'b0000;
    in_data         = {6'h04, 6'h03, 6'h02, 6'h01};
    out_almost_full = 1'b0;
    out_full        = 1'b0;
    out_error       = 1'b0;

    // Reset values; pops forced off during reset even with data available.
    #2;
    chk("rst_in_rd", 32'(in_rd), 32'h0);
    chk("rst_out_wr", 32'(out_wr), 32'h0);
    chk("rst_out_data", 32'(out_data), 32'h0);
    chk("rst_grant", 32'(grant), 32'h0);
    chk("rst_state", 32'(state), 32'h0);
    chk("rst_xfer", 32'(xfer_count), 32'h0);
    in_empty = 4'b1111;
    tick();
    tick();
    reset_L = 1'b1;

    // All empty for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("idle_in_rd", 32'(in_rd), 32'h0);
      tick();
    end
    chk("idle_out_wr", 32'(out_wr), 32'h0);
    chk("idle_state", 32'(state), 32'h0);
    chk("idle_xfer", 32'(xfer_count), 32'h0);

    // All non-empty: strict rotation 0,1,2,3,0,...
    in_empty = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_in_rd", 32'(in_rd), 32'(4'b0001 << (i % 4)));
      tick();
      chk("rr_out_wr", 32'(out_wr), 32'h1);
      chk("rr_out_data", 32'(out_data), 32'((i % 4) + 1));
      chk("rr_grant", 32'(grant), 32'(i % 4));
    end
    chk("rr_xfer", 32'(xfer_count), 32'd8);
    chk("rr_state", 32'(state), 32'd1);

    // FIFOs 1 and 3 only: skipped empties cost no cycles.
    in_empty = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("skip_in_rd", 32'(in_rd), (i % 2 == 0) ? 32'h2 : 32'h8);
      tick();
      chk("skip_out_wr", 32'(out_wr), 32'h1);
      chk("skip_grant", 32'(grant), (i % 2 == 0) ? 32'd1 : 32'd3);
      chk("skip_out_data", 32'(out_data), (i % 2 == 0) ? 32'h2 : 32'h4);
    end
    chk("skip_xfer", 32'(xfer_count), 32'd12);

    // Stream one word (FIFO 0), then almost_full for 3 cycles.
    in_empty = 4'b0000;
    #1;
    chk("bp_pre_in_rd", 32'(in_rd), 32'h1);
    tick();
    out_almost_full = 1'b1;
    #1;
    chk("bp_in_rd_0", 32'(in_rd), 32'h0);
    chk("bp_trailing_wr", 32'(out_wr), 32'h1);
    chk("bp_trailing_data", 32'(out_data), 32'h1);
    tick();
    for (int i = 1; i < 3; i++) begin
      #1;
      chk("bp_in_rd", 32'(in_rd), 32'h0);
      chk("bp_out_wr", 32'(out_wr), 32'h0);
      chk("bp_state", 32'(state), 32'd2);
      tick();
    end
    chk("bp_state_end", 32'(state), 32'd2);
    out_almost_full = 1'b0;
    #1;
    chk("bp_resume_in_rd", 32'(in_rd), 32'h2);
    tick();
    chk("bp_resume_grant", 32'(grant), 32'd1);
    chk("bp_resume_data", 32'(out_data), 32'h2);
    chk("bp_resume_state", 32'(state), 32'd1);
    chk("bp_xfer", 32'(xfer_count), 32'd14);

    // Error in the same cycle as a would-be pop: error wins, ERROR is sticky.
    in_error = 4'b0100;
    #1;
    chk("err_in_rd", 32'(in_rd), 32'h0);
    chk("err_inflight_wr", 32'(out_wr), 32'h1);
    tick();
    in_error = 4'b0000;
    #1;
    chk("err_state", 32'(state), 32'd3);
    chk("err_in_rd_after", 32'(in_rd), 32'h0);
    chk("err_out_wr", 32'(out_wr), 32'h0);
    tick();
    tick();
    chk("err_sticky", 32'(state), 32'd3);
    chk("err_sticky_wr", 32'(out_wr), 32'h0);
    chk("err_xfer", 32'(xfer_count), 32'd14);
    reset_L = 1'b0;
    #1;
    chk("err_reset_state", 32'(state), 32'd0);
    reset_L = 1'b1;

    // Async reset mid-transfer clears everything at once.
    tick();
    tick();
    chk("mid_pre_wr", 32'(out_wr), 32'h1);
    #2;
    reset_L = 1'b0;
    #1;
    chk("mid_in_rd", 32'(in_rd), 32'h0);
    chk("mid_out_wr", 32'(out_wr), 32'h0);
    chk("mid_out_data", 32'(out_data), 32'h0);
    chk("mid_grant", 32'(grant), 32'h0);
    chk("mid_state", 32'(state), 32'h0);
    chk("mid_xfer", 32'(xfer_count), 32'h0);
    tick();
    reset_L = 1'b1;

    // Single non-empty FIFO served every cycle; counter wraps 0xFFFF -> 0.
    in_empty = 4'b1011;
    #1;
    chk("single_in_rd", 32'(in_rd), 32'h4);
    for (int i = 0; i < 65534; i++) begin
      tick();
    end
    chk("wrap_fffe", 32'(xfer_count), 32'hFFFE);
    chk("single_grant", 32'(grant), 32'd2);
    chk("single_out_wr", 32'(out_wr), 32'h1);
    chk("single_data", 32'(out_data), 32'h3);
    tick();
    chk("wrap_ffff", 32'(xfer_count), 32'hFFFF);
    tick();
    chk("wrap_zero", 32'(xfer_count), 32'h0);
    chk("wrap_state", 32'(state), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
